// File: rtl/bus_peripheral_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_peripheral_unit
// Description : Memory-mapped slave on the CPU MEM-stage bus. Serves a
//               word-addressed data RAM and a small peripheral register file
//               (interval timer, LEDs, 7-seg digits, free-running systick).
// Ports       : clk               - system clock, rising edge
//               reset             - asynchronous active-high reset
//               MemRead/MemWrite  - bus strobes from the MEM stage
//               MemBus_Address    - byte address, bits[1:0] ignored
//               MemBus_Write_Data - store data
//               Device_Read_Data  - combinational load data (0 when idle)
//               irq               - timer interrupt level (TCON[2])
//               leds, digits      - LED and 7-seg register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module bus_peripheral_unit #(
  parameter int          RAM_WORDS = 512,
  parameter logic [31:0] PERI_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] TL_MAX    = 32'hFFFF_FFFF;

  // Peripheral word offsets
  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LEDS = 3'd3;
  localparam logic [2:0] OFF_DIGI = 3'd4;
  localparam logic [2:0] OFF_TICK = 3'd5;

  // Storage
  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] th_q,   th_d;
  logic [31:0] tl_q,   tl_d;
  logic [2:0]  tcon_q, tcon_d;   // {status, irq_en, enable}
  logic [7:0]  leds_q, leds_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] tick_q, tick_d;

  // Address decode
  logic          ram_hit;
  logic          peri_hit;
  logic [29:0]   peri_word;
  logic [2:0]    peri_off;
  logic [AW-1:0] ram_idx;
  logic          wr_ram, wr_th, wr_tl, wr_tcon, wr_leds, wr_digi;
  logic          tl_wrap;

  assign ram_hit   = (MemBus_Address < RAM_BYTES);
  assign ram_idx   = MemBus_Address[AW+1:2];
  // Word distance from the peripheral base; addresses below the base wrap
  // to a huge value and therefore never hit.
  assign peri_word = MemBus_Address[31:2] - PERI_BASE[31:2];
  assign peri_off  = peri_word[2:0];
  assign peri_hit  = !ram_hit && (peri_word[29:3] == '0) && (peri_off <= OFF_TICK);

  assign wr_ram  = MemWrite && ram_hit;
  assign wr_th   = MemWrite && peri_hit && (peri_off == OFF_TH);
  assign wr_tl   = MemWrite && peri_hit && (peri_off == OFF_TL);
  assign wr_tcon = MemWrite && peri_hit && (peri_off == OFF_TCON);
  assign wr_leds = MemWrite && peri_hit && (peri_off == OFF_LEDS);
  assign wr_digi = MemWrite && peri_hit && (peri_off == OFF_DIGI);

  assign tl_wrap = tcon_q[0] && (tl_q == TL_MAX);

  // Next-state logic for the register file
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    leds_d = leds_q;
    digi_d = digi_q;
    tick_d = tick_q + 32'd1;

    if (tcon_q[0]) begin
      tl_d = tl_wrap ? th_q : tl_q + 32'd1;
    end
    // CPU store beats the timer's own update of TL
    if (wr_tl) begin
      tl_d = MemBus_Write_Data;
    end
    if (wr_th) begin
      th_d = MemBus_Write_Data;
    end
    // Status bit can only be cleared by software, never set
    if (wr_tcon) begin
      tcon_d = {tcon_q[2] & MemBus_Write_Data[2], MemBus_Write_Data[1:0]};
    end
    // Overflow set wins over a simultaneous software clear
    if (tl_wrap && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
    if (wr_leds) begin
      leds_d = MemBus_Write_Data[7:0];
    end
    if (wr_digi) begin
      digi_d = MemBus_Write_Data[11:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      leds_q <= '0;
      digi_q <= '0;
      tick_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      leds_q <= leds_d;
      digi_q <= digi_d;
      tick_q <= tick_d;
    end
  end

  // RAM has no reset; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (wr_ram && !reset) begin
      ram_q[ram_idx] <= MemBus_Write_Data;
    end
  end

  // Zero-latency read mux; returns the pre-write value on read+write
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      if (ram_hit) begin
        Device_Read_Data = ram_q[ram_idx];
      end else if (peri_hit) begin
        case (peri_off)
          OFF_TH:   Device_Read_Data = th_q;
          OFF_TL:   Device_Read_Data = tl_q;
          OFF_TCON: Device_Read_Data = {29'd0, tcon_q};
          OFF_LEDS: Device_Read_Data = {24'd0, leds_q};
          OFF_DIGI: Device_Read_Data = {20'd0, digi_q};
          OFF_TICK: Device_Read_Data = tick_q;
          default:  Device_Read_Data = '0;
        endcase
      end
    end
  end

  assign irq    = tcon_q[2];
  assign leds   = leds_q;
  assign digits = digi_q;

endmodule
`default_nettype wire
